// File: rtl/soc_it_msg_send_ctrl_pkg.sv
// Shared types for the SOC_IT message send path: word width, FSM states, and the buffered word format.
package soc_it_msg_pkg;

  localparam int MSG_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } msg_state_e;

  // One buffered word: payload plus its end-of-message marker.
  typedef struct packed {
    logic             last;
    logic [MSG_W-1:0] data;
  } msg_word_t;

endpackage

// File: rtl/soc_it_msg_send_ctrl_if.sv
// User word stream and SOC_IT request/ack + beat stream, bundled as one port.
interface soc_it_msg_send_ctrl_if;
  import soc_it_msg_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] in_data;
  logic             in_last;
  logic             recv_msg_request;
  logic             recv_msg_ack;
  logic             recv_msg_src_rdy;
  logic             recv_msg_dst_rdy;
  logic [MSG_W-1:0] recv_msg_payload;

  modport master (
    output in_valid, in_data, in_last, recv_msg_ack, recv_msg_dst_rdy,
    input  in_ready, recv_msg_request, recv_msg_src_rdy, recv_msg_payload
  );

  modport slave (
    input  in_valid, in_data, in_last, recv_msg_ack, recv_msg_dst_rdy,
    output in_ready, recv_msg_request, recv_msg_src_rdy, recv_msg_payload
  );

endinterface

// File: rtl/soc_it_msg_send_ctrl_fifo.sv
// Show-ahead word FIFO: rd_data always shows the head entry; no write-to-read bypass.
module soc_it_msg_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/soc_it_msg_send_ctrl.sv
// Buffers user message words, frames them (truncating at MAX_BEATS) and offers only
// complete messages to SOC_IT via request/ack followed by a src_rdy/dst_rdy beat stream.
module soc_it_msg_send_ctrl
  import soc_it_msg_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_BEATS   = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  soc_it_msg_send_ctrl_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0]   msg_pending,
  output logic                          ack_timeout,
  output logic                          len_err
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] REQ  = ST_REQ;
  localparam logic [1:0] XFER = ST_XFER;

  logic [1:0]    state;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] tmo_cnt;

  msg_word_t     wr_word;
  msg_word_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [PW-1:0] fifo_cnt;

  logic          wr;
  logic          at_max;
  logic          pop;
  logic          last_pop;

  // in_ready is held low while reset is applied, then follows FIFO space.
  assign bus.in_ready = rst && !fifo_full;
  assign wr           = bus.in_valid && bus.in_ready;
  assign at_max       = (beat_cnt == BW'(MAX_BEATS - 1));

  assign wr_word.data = bus.in_data;
  assign wr_word.last = bus.in_last || at_max;

  assign pop      = (state == XFER) && bus.recv_msg_dst_rdy && !fifo_empty;
  assign last_pop = pop && head.last;

  soc_it_msg_fifo #(
    .W     (MSG_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // Write-side framing: a word reaching MAX_BEATS closes the message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt    <= '0;
      len_err     <= 1'b0;
      msg_pending <= '0;
    end else begin
      if (wr) begin
        beat_cnt <= wr_word.last ? '0 : beat_cnt + 1'b1;
        if (at_max && !bus.in_last) len_err <= 1'b1;
      end
      case ({wr && wr_word.last, last_pop})
        2'b10:   msg_pending <= msg_pending + 1'b1;
        2'b01:   msg_pending <= msg_pending - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      ack_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (msg_pending != '0 && fifo_cnt != '0) begin
            state   <= REQ;
            tmo_cnt <= '0;
          end
        end
        REQ: begin
          if (bus.recv_msg_ack) begin
            state <= XFER;
          end else begin
            // Saturating wait counter; the request is never withdrawn.
            if (tmo_cnt != TW'(ACK_TIMEOUT)) tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) ack_timeout <= 1'b1;
          end
        end
        XFER: begin
          if (last_pop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.recv_msg_request = (state != IDLE);
  assign bus.recv_msg_src_rdy = (state == XFER);
  assign bus.recv_msg_payload = (state == XFER) ? head.data : '0;

endmodule

// File: tb/tb_soc_it_msg_send_ctrl.sv
// Scoreboard bench: the driver pushes expected beats as words are accepted, a negedge monitor
// pops and checks every presented beat, framing boundary and post-message idle.
module tb_soc_it_msg_send_ctrl;
  import soc_it_msg_pkg::*;

  localparam int FD = 16;
  localparam int MB = 16;
  localparam int AT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  soc_it_msg_send_ctrl_if bus();
  logic [$clog2(FD):0] msg_pending;
  logic                ack_timeout;
  logic                len_err;

  soc_it_msg_send_ctrl #(
    .FIFO_DEPTH  (FD),
    .MAX_BEATS   (MB),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .msg_pending (msg_pending),
    .ack_timeout (ack_timeout),
    .len_err     (len_err)
  );

  typedef struct {
    logic [127:0] data;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int    errs = 0;
  int    checks = 0;
  int    xfers = 0;
  int    mdl_beats = 0;
  bit    mdl_len_err = 0;
  bit    chk_idle = 0;
  bit    rnd_mode = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every presented beat must match the queue head; after a last beat the port idles.
  always @(negedge clk) begin
    if (!rst) begin
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        chk("idle_after_last", {126'b0, bus.recv_msg_request, bus.recv_msg_src_rdy}, 128'd0);
        chk_idle = 0;
      end
      if (bus.recv_msg_src_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {127'b0, bus.recv_msg_src_rdy}, 128'd0);
        end else begin
          chk("payload", bus.recv_msg_payload, exp_q[0].data);
          if (bus.recv_msg_dst_rdy) begin
            beat_t b;
            b = exp_q.pop_front();
            xfers++;
            if (b.last) chk_idle = 1;
          end
        end
      end
    end
  end

  // Random SOC_IT-side behaviour when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (rnd_mode) begin
      bus.recv_msg_dst_rdy = 1'($urandom_range(0, 1));
      bus.recv_msg_ack     = ($urandom_range(0, 2) == 0);
    end
  end

  // Reference framing: messages are cut after MB words when no last arrives.
  task automatic model_accept(logic [127:0] d, logic last);
    beat_t b;
    mdl_beats++;
    b.data = d;
    b.last = last || (mdl_beats == MB);
    if (!last && mdl_beats == MB) mdl_len_err = 1;
    if (b.last) mdl_beats = 0;
    exp_q.push_back(b);
  endtask

  task automatic send_word(logic [127:0] d, logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", {127'b0, bus.in_ready}, 128'd1);
    end else begin
      @(posedge clk);
      model_accept(d, last);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.recv_msg_request && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("request_seen", {127'b0, bus.recv_msg_request}, 128'd1);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic ack_once();
    bus.recv_msg_ack = 1'b1;
    @(posedge clk); #1;
    bus.recv_msg_ack = 1'b0;
  endtask

  initial begin
    logic [11:0] req_t;
    logic [4:0]  pend_t [12];
    int          z;
    int          seen;
    int          x0;

    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0;
    bus.recv_msg_ack = 0; bus.recv_msg_dst_rdy = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
    chk("rst_outputs", {bus.recv_msg_request, bus.recv_msg_src_rdy, ack_timeout, len_err},
        128'd0);
    chk("rst_pending", 128'(msg_pending), 128'd0);
    #2 rst = 1'b1;
    #1 chk("in_ready_after_rst", {127'b0, bus.in_ready}, 128'd1);
    @(posedge clk); #1;

    // 3-word message, ack two cycles after request
    bus.recv_msg_dst_rdy = 1'b1;
    send_word(128'h1, 0);
    send_word(128'h2, 0);
    send_word(128'h3, 1);
    chk("pend_after_last", 128'(msg_pending), 128'd1);
    chk("req_low_at_E", {127'b0, bus.recv_msg_request}, 128'd0);
    @(posedge clk); #1;
    chk("req_high_E1", {bus.recv_msg_request, bus.recv_msg_src_rdy}, 128'd2);
    @(posedge clk); #1;
    ack_once();
    chk("src_rdy_after_ack", {127'b0, bus.recv_msg_src_rdy}, 128'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("req_low_after_3", {127'b0, bus.recv_msg_request}, 128'd0);
    chk("pend_zero_1", 128'(msg_pending), 128'd0);

    // Same message, dst_rdy toggling
    bus.recv_msg_dst_rdy = 1'b0;
    send_word(128'h1, 0);
    send_word(128'h2, 0);
    send_word(128'h3, 1);
    wait_req();
    ack_once();
    x0 = xfers;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      bus.recv_msg_dst_rdy = (i % 2 == 0);
      @(posedge clk); #1;
    end
    bus.recv_msg_dst_rdy = 1'b0;
    chk("toggle_xfers", 128'(xfers - x0), 128'd3);
    @(posedge clk); #1;

    // Two 1-word messages, ack always high
    bus.recv_msg_ack = 1'b1;
    bus.recv_msg_dst_rdy = 1'b1;
    send_word(128'hA1, 1);
    send_word(128'hA2, 1);
    chk("pend_two", 128'(msg_pending), 128'd2);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      req_t[i]  = bus.recv_msg_request;
      pend_t[i] = msg_pending;
    end
    z = 11;
    for (int i = 10; i >= 0; i--) if (!req_t[i]) z = i;
    chk("one_idle_gap", {126'b0, req_t[z], req_t[z+1]}, 128'd1);
    chk("pend_mid", 128'(pend_t[z]), 128'd1);
    chk("pend_end", 128'(pend_t[11]), 128'd0);
    bus.recv_msg_ack = 1'b0;

    // Over-long message: truncated at MB words, remainder starts the next message
    rnd_mode = 1;
    for (int i = 0; i < 17; i++) begin
      send_word(128'h100 + 128'(i), 0);
      if (i == 14) chk("len_err_before", {127'b0, len_err}, 128'd0);
      if (i == 15) chk("len_err_at_16", {127'b0, len_err}, 128'd1);
    end
    send_word(128'h200, 1);
    drain(2000);
    rnd_mode = 0;
    @(posedge clk); #1;
    bus.recv_msg_ack = 0;

    // Ack withheld past the timeout, then a late ack
    bus.recv_msg_dst_rdy = 1'b1;
    send_word(128'hBEEF, 1);
    wait_req();
    repeat (1000) @(posedge clk);
    #1;
    chk("tmo_not_yet", {bus.recv_msg_request, ack_timeout}, 128'd2);
    repeat (100) @(posedge clk);
    #1;
    chk("tmo_set", {bus.recv_msg_request, ack_timeout}, 128'd3);
    ack_once();
    drain(50);
    @(posedge clk); #1;
    chk("pend_after_late", 128'(msg_pending), 128'd0);

    // Reset during beat 2 of 4
    send_word(128'hC1, 0);
    send_word(128'hC2, 0);
    send_word(128'hC3, 0);
    send_word(128'hC4, 1);
    wait_req();
    ack_once();
    @(posedge clk); #1;
    #2;
    rst = 1'b0;
    exp_q.delete();
    mdl_beats = 0;
    mdl_len_err = 0;
    #1;
    chk("async_rst_outs", {bus.recv_msg_request, bus.recv_msg_src_rdy, bus.in_ready,
        ack_timeout, len_err}, 128'd0);
    chk("async_rst_payload", bus.recv_msg_payload, 128'd0);
    chk("async_rst_pend", 128'(msg_pending), 128'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    bus.recv_msg_ack = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen += bus.recv_msg_request;
    end
    chk("no_req_after_rst", 128'(seen), 128'd0);
    bus.recv_msg_ack = 1'b0;

    // Randomized traffic
    rnd_mode = 1;
    for (int m = 0; m < 25; m++) begin
      int len = $urandom_range(1, 20);
      for (int w = 0; w < len; w++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_word({$urandom, $urandom, $urandom, $urandom}, (w == len - 1));
      end
    end
    drain(20000);
    rnd_mode = 0;
    @(posedge clk); #1;
    chk("rand_len_err", {127'b0, len_err}, {127'b0, mdl_len_err});
    chk("rand_pend_end", 128'(msg_pending), 128'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
